// File: rtl/m68k_bus_ctrl.sv
// 68000 bus-cycle sequencer: runs S0-S7 with wait states until DTACK/BERR/VPA,
// and generates the free-running 6800 E clock plus VMA for VPA-synchronous cycles.
module m68k_bus_ctrl (
  input  logic        MCLK,
  input  logic        RESET_N,
  input  logic        CLK_R,
  input  logic        CLK_F,
  input  logic        req,
  input  logic        req_rw,
  input  logic        req_uds,
  input  logic        req_lds,
  input  logic [2:0]  req_fc,
  input  logic [22:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        ack,
  output logic [15:0] rdata,
  output logic        berr_flag,
  output logic [22:0] ADDRESS,
  output logic [2:0]  FC,
  output logic        RW,
  output logic        AS,
  output logic        UDS,
  output logic        LDS,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  input  logic [15:0] DATA_IN,
  input  logic        DTACK,
  input  logic        BERR,
  input  logic        VPA,
  output logic        E_CLK,
  output logic        VMA
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_S0, ST_S1, ST_S2, ST_S3, ST_S4, ST_S5, ST_S6, ST_S7, ST_SW
  } state_t;

  state_t      state, state_nxt;
  logic        start, cycle_end, term_berr, term_ok, enter_vpa;
  logic        lat_rw, lat_uds, lat_lds;
  logic [22:0] lat_addr;
  logic [15:0] lat_wdata;
  logic [3:0]  ecnt, ecnt_nxt;
  logic        vpa_mode, vpa_armed, vpa_ready;

  assign ecnt_nxt  = (ecnt == 4'd9) ? 4'd0 : ecnt + 4'd1;
  // A VPA cycle may only finish in the last E-high clock, so data is taken at E fall.
  assign vpa_ready = vpa_armed && (ecnt == 4'd9);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no latch can be inferred.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    cycle_end = 1'b0;
    term_berr = 1'b0;
    term_ok   = 1'b0;
    enter_vpa = 1'b0;
    unique case (state)
      ST_IDLE: if (CLK_R && req) begin
        state_nxt = ST_S0;
        start     = 1'b1;
      end
      ST_S0: if (CLK_F) state_nxt = ST_S1;
      ST_S1: if (CLK_R) state_nxt = ST_S2;
      ST_S2: if (CLK_F) state_nxt = ST_S3;
      ST_S3: if (CLK_R) state_nxt = ST_S4;
      ST_S4: if (CLK_F) begin
        if (!BERR) begin
          state_nxt = ST_S5;
          term_berr = 1'b1;
        end else if (!DTACK || vpa_ready) begin
          state_nxt = ST_S5;
          term_ok   = 1'b1;
        end else begin
          state_nxt = ST_SW;
          enter_vpa = !VPA;
        end
      end
      ST_SW: if (CLK_R) state_nxt = ST_S4;
      ST_S5: if (CLK_R) state_nxt = ST_S6;
      ST_S6: if (CLK_F) state_nxt = ST_S7;
      ST_S7: if (CLK_R) begin
        cycle_end = 1'b1;
        if (req) begin
          state_nxt = ST_S0;
          start     = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge MCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ack       <= 1'b0;
      rdata     <= '0;
      berr_flag <= 1'b0;
      ADDRESS   <= '0;
      FC        <= '0;
      RW        <= 1'b1;
      AS        <= 1'b1;
      UDS       <= 1'b1;
      LDS       <= 1'b1;
      DATA_OUT  <= '0;
      DATA_OE   <= 1'b0;
      E_CLK     <= 1'b0;
      VMA       <= 1'b1;
      ecnt      <= '0;
      vpa_mode  <= 1'b0;
      vpa_armed <= 1'b0;
      lat_rw    <= 1'b1;
      lat_uds   <= 1'b0;
      lat_lds   <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      ack <= 1'b0;

      if (CLK_R) begin
        ecnt  <= ecnt_nxt;
        E_CLK <= (ecnt_nxt >= 4'd6);
        if (vpa_mode && !vpa_armed && (ecnt_nxt <= 4'd5)) begin
          vpa_armed <= 1'b1;
          VMA       <= 1'b0;
        end
      end

      if (cycle_end) begin
        RW        <= 1'b1;
        DATA_OE   <= 1'b0;
        vpa_mode  <= 1'b0;
        vpa_armed <= 1'b0;
        VMA       <= 1'b1;
      end

      // Placed after cycle_end so a back-to-back request's direction wins over the release.
      if (start) begin
        lat_rw    <= req_rw;
        lat_uds   <= req_uds;
        lat_lds   <= req_lds;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        FC        <= req_fc;
        RW        <= req_rw;
      end

      if (state == ST_S0 && CLK_F) ADDRESS <= lat_addr;

      if (state == ST_S1 && CLK_R) begin
        AS <= 1'b0;
        if (lat_rw) begin
          UDS <= ~lat_uds;
          LDS <= ~lat_lds;
        end
      end

      if (state == ST_S2 && CLK_F && !lat_rw) begin
        DATA_OE  <= 1'b1;
        DATA_OUT <= lat_wdata;
      end

      if (state == ST_S3 && CLK_R && !lat_rw) begin
        UDS <= ~lat_uds;
        LDS <= ~lat_lds;
      end

      if (term_berr) berr_flag <= 1'b1;
      if (term_ok)   berr_flag <= 1'b0;
      if (enter_vpa) vpa_mode  <= 1'b1;

      if (state == ST_S6 && CLK_F) begin
        if (lat_rw && !berr_flag) rdata <= DATA_IN;
        ack <= 1'b1;
        AS  <= 1'b1;
        UDS <= 1'b1;
        LDS <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_m68k_bus_ctrl.sv
// Directed bench for m68k_bus_ctrl: CPU clock is 4 MCLKs (CLK_R, idle, CLK_F, idle);
// cycle timings are counted in MCLK negedges from the request's CLK_R edge.
module tb_m68k_bus_ctrl;

  localparam int NEVER = 100000;

  logic        MCLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        CLK_R = 1'b0, CLK_F = 1'b0;
  logic        req = 1'b0, req_rw = 1'b1, req_uds = 1'b0, req_lds = 1'b0;
  logic [2:0]  req_fc = '0;
  logic [22:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        ack, berr_flag, RW, AS, UDS, LDS, DATA_OE, E_CLK, VMA;
  logic [15:0] rdata, DATA_OUT;
  logic [22:0] ADDRESS;
  logic [2:0]  FC;
  logic [15:0] DATA_IN = '0;
  logic        DTACK = 1'b1, BERR = 1'b1, VPA = 1'b1;

  int n_tests = 0, n_fail = 0;
  int phase = 3, ecnt_m = 0;
  int as_n, ds_n, oe_n, vma_n, ack_n;
  logic uds_lo, lds_lo, rw_at_as;

  m68k_bus_ctrl dut (
    .MCLK(MCLK), .RESET_N(RESET_N), .CLK_R(CLK_R), .CLK_F(CLK_F),
    .req(req), .req_rw(req_rw), .req_uds(req_uds), .req_lds(req_lds),
    .req_fc(req_fc), .req_addr(req_addr), .req_wdata(req_wdata),
    .ack(ack), .rdata(rdata), .berr_flag(berr_flag),
    .ADDRESS(ADDRESS), .FC(FC), .RW(RW), .AS(AS), .UDS(UDS), .LDS(LDS),
    .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE), .DATA_IN(DATA_IN),
    .DTACK(DTACK), .BERR(BERR), .VPA(VPA), .E_CLK(E_CLK), .VMA(VMA)
  );

  initial forever #5 MCLK = ~MCLK;

  // Strobe generator plus reference E counter (0-9, advances on CLK_R).
  initial forever begin
    @(posedge MCLK);
    if (!RESET_N)   ecnt_m = 0;
    else if (CLK_R) ecnt_m = (ecnt_m == 9) ? 0 : ecnt_m + 1;
    #1;
    phase = (phase + 1) % 4;
    CLK_R = (phase == 0);
    CLK_F = (phase == 2);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stop at the negedge just before a CLK_R edge (optionally one whose new ecnt is want+1).
  task automatic align(input int want);
    int k = 0;
    logic ok;
    do begin
      @(negedge MCLK);
      k++;
    end while ((CLK_R !== 1'b1 || (want >= 0 && ecnt_m != want)) && k < 200);
    ok = (CLK_R === 1'b1) && (want < 0 || ecnt_m == want);
    check("align", ok, 1'b1);
  endtask

  task automatic drive_term(input int n, input int dt_at, input int be_at, input int vp_at);
    DTACK = (n >= dt_at) ? 1'b0 : 1'b1;
    BERR  = (n >= be_at) ? 1'b0 : 1'b1;
    VPA   = (n >= vp_at) ? 1'b0 : 1'b1;
  endtask

  // One request, req dropped at ack; returns one negedge after the ack pulse (still in S7).
  task automatic run_cycle(input logic rw, input logic uds, input logic lds,
                           input logic [2:0] fc, input logic [22:0] addr,
                           input logic [15:0] wd, input int dt_at, input int be_at,
                           input int vp_at, input int want_ecnt);
    int n = 0;
    align(want_ecnt);
    req_rw = rw; req_uds = uds; req_lds = lds;
    req_fc = fc; req_addr = addr; req_wdata = wd; req = 1'b1;
    as_n = 0; ds_n = 0; oe_n = 0; vma_n = 0; ack_n = 0;
    uds_lo = 1'b0; lds_lo = 1'b0; rw_at_as = 1'bx;
    drive_term(0, dt_at, be_at, vp_at);
    while (ack_n == 0 && n < 400) begin
      @(negedge MCLK);
      n++;
      if (!AS && as_n == 0) begin as_n = n; rw_at_as = RW; end
      if ((!UDS || !LDS) && ds_n == 0) ds_n = n;
      if (!UDS) uds_lo = 1'b1;
      if (!LDS) lds_lo = 1'b1;
      if (DATA_OE && oe_n == 0) oe_n = n;
      if (!VMA && vma_n == 0) vma_n = n;
      if (ack) begin ack_n = n; req = 1'b0; end
      drive_term(n, dt_at, be_at, vp_at);
    end
    check("ack_seen", (ack_n != 0), 1'b1);
    req = 1'b0;
    @(negedge MCLK);
    check("ack_pulse", ack, 1'b0);
    DTACK = 1'b1; BERR = 1'b1; VPA = 1'b1;
  endtask

  initial begin
    int n, k, ack1, ack2;
    logic [15:0] rd1;
    logic as20, as21;

    // Reset values
    repeat (3) @(negedge MCLK);
    check("rst_strobes", {AS, UDS, LDS, VMA, RW}, 5'b11111);
    check("rst_low", {DATA_OE, ack, berr_flag, E_CLK}, 4'b0000);
    check("rst_addr", ADDRESS, 0);
    check("rst_fc", FC, 0);
    check("rst_dout", DATA_OUT, 0);
    check("rst_rdata", rdata, 0);
    RESET_N = 1'b1;

    // Free-running E clock: high when ecnt >= 6
    for (int i = 0; i < 12; i++) begin
      align(-1);
      @(negedge MCLK);
      check("e_clk", E_CLK, (ecnt_m >= 6));
    end

    // Zero-wait read
    DATA_IN = 16'hBEEF;
    run_cycle(1'b1, 1'b1, 1'b1, 3'b110, 23'h091A2B, 16'h0, 0, NEVER, NEVER, -1);
    check("rd_ack_n", ack_n, 15);
    check("rd_as_n", as_n, 5);
    check("rd_ds_n", ds_n, 5);
    check("rd_bytes", {uds_lo, lds_lo}, 2'b11);
    check("rd_rw", rw_at_as, 1'b1);
    check("rd_oe_n", oe_n, 0);
    check("rd_rdata", rdata, 16'hBEEF);
    check("rd_berr", berr_flag, 1'b0);
    check("rd_addr", ADDRESS, 23'h091A2B);
    check("rd_fc", FC, 3'b110);
    check("rd_strobes_off", {AS, UDS, LDS}, 3'b111);

    // Write, lower byte, two wait states
    run_cycle(1'b0, 1'b0, 1'b1, 3'b101, 23'h012345, 16'h1234, 16, NEVER, NEVER, -1);
    check("wr_ack_n", ack_n, 23);
    check("wr_as_n", as_n, 5);
    check("wr_ds_n", ds_n, 9);
    check("wr_bytes", {uds_lo, lds_lo}, 2'b01);
    check("wr_rw", rw_at_as, 1'b0);
    check("wr_oe_n", oe_n, 7);
    check("wr_dout", DATA_OUT, 16'h1234);
    check("wr_oe_s7", {DATA_OE, RW}, 2'b10);
    check("wr_rdata_kept", rdata, 16'hBEEF);
    @(negedge MCLK);
    check("wr_release", {DATA_OE, RW}, 2'b01);

    // BERR and DTACK together: BERR wins, rdata holds
    DATA_IN = 16'h0BAD;
    run_cycle(1'b1, 1'b1, 1'b1, 3'b110, 23'h000010, 16'h0, 0, 0, NEVER, -1);
    check("be_ack_n", ack_n, 15);
    check("be_flag", berr_flag, 1'b1);
    check("be_rdata", rdata, 16'hBEEF);

    // VPA read issued with new ecnt = 7
    DATA_IN = 16'h5A5A;
    run_cycle(1'b1, 1'b1, 1'b0, 3'b111, 23'h7FFFF0, 16'h0, NEVER, NEVER, 0, 6);
    check("vpa_vma_n", vma_n, 13);
    check("vpa_ack_n", ack_n, 55);
    check("vpa_rdata", rdata, 16'h5A5A);
    check("vpa_berr", berr_flag, 1'b0);
    check("vpa_eclk", E_CLK, 1'b0);
    check("vpa_bytes", {uds_lo, lds_lo}, 2'b10);
    check("vpa_vma_s7", VMA, 1'b0);
    @(negedge MCLK);
    check("vpa_vma_off", VMA, 1'b1);

    // Back-to-back reads, fields changed at the first ack
    DATA_IN = 16'hAAAA;
    align(-1);
    req_rw = 1'b1; req_uds = 1'b1; req_lds = 1'b1;
    req_fc = 3'b101; req_addr = 23'h000100; req = 1'b1;
    drive_term(0, 0, NEVER, NEVER);
    n = 0; ack1 = 0; ack2 = 0; rd1 = '0; as20 = 1'b0; as21 = 1'b1;
    while (ack2 == 0 && n < 200) begin
      @(negedge MCLK);
      n++;
      if (ack) begin
        if (ack1 == 0) begin
          ack1 = n; rd1 = rdata;
          req_fc = 3'b010; req_addr = 23'h000200; DATA_IN = 16'h5555;
        end else begin
          ack2 = n; req = 1'b0;
        end
      end
      if (n == 20) as20 = AS;
      if (n == 21) as21 = AS;
    end
    req = 1'b0;
    DTACK = 1'b1;
    check("b2b_ack1", ack1, 15);
    check("b2b_rd1", rd1, 16'hAAAA);
    check("b2b_as_gap", {as20, as21}, 2'b10);
    check("b2b_ack2", ack2, 31);
    check("b2b_rd2", rdata, 16'h5555);
    check("b2b_addr2", ADDRESS, 23'h000200);
    check("b2b_fc2", FC, 3'b010);

    // Reset during S4 of a write, then a normal read
    align(-1);
    req_rw = 1'b0; req_uds = 1'b1; req_lds = 1'b1;
    req_fc = 3'b001; req_addr = 23'h055555; req_wdata = 16'hFACE; req = 1'b1;
    drive_term(0, NEVER, NEVER, NEVER);
    repeat (10) @(negedge MCLK);
    check("mid_active", {AS, UDS, LDS, DATA_OE}, 4'b0001);
    RESET_N = 1'b0;
    #1;
    check("mid_rst_strobes", {AS, UDS, LDS, VMA, RW}, 5'b11111);
    check("mid_rst_low", {DATA_OE, ack, berr_flag, E_CLK}, 4'b0000);
    check("mid_rst_addr", ADDRESS, 0);
    check("mid_rst_dout", DATA_OUT, 0);
    check("mid_rst_rdata", rdata, 0);
    req = 1'b0;
    k = 0;
    repeat (4) begin @(negedge MCLK); if (ack) k++; end
    RESET_N = 1'b1;
    repeat (12) begin @(negedge MCLK); if (ack) k++; end
    check("mid_no_ack", k, 0);
    check("mid_idle_as", AS, 1'b1);

    DATA_IN = 16'hC0DE;
    run_cycle(1'b1, 1'b1, 1'b1, 3'b110, 23'h000ABC, 16'h0, 0, NEVER, NEVER, -1);
    check("post_ack_n", ack_n, 15);
    check("post_rdata", rdata, 16'hC0DE);
    check("post_addr", ADDRESS, 23'h000ABC);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m68k_bus_ctrl.md
# m68k_bus_ctrl

Asynchronous bus-cycle sequencer for the 68000 core, downstream of the address/data register unit. It takes one transfer request per cycle (address, function code, direction, byte strobes, write data) and runs the S0–S7 bus state sequence on the external 68000 bus. It drives AS/UDS/LDS/RW/FC/ADDRESS and inserts wait states until DTACK, BERR or VPA terminates the cycle. It also generates E_CLK/VMA for VPA-synchronous cycles and returns read data plus a completion pulse to the core.

## Interface
Parameters: none.

- MCLK  in  1  master clock; every flop in the block is clocked by it.
- RESET_N  in  1  reset, asynchronous and active-low.
- CLK_R  in  1  one-MCLK strobe at each CPU clock rising edge.
- CLK_F  in  1  one-MCLK strobe at each CPU clock falling edge; never coincides with CLK_R.
- req  in  1  transfer request, level; held until ack.
- req_rw  in  1  1 = read, 0 = write.
- req_uds, req_lds  in  1  byte enables, active-high.
- req_fc  in  3  function code.
- req_addr  in  23  word address [23:1].
- req_wdata  in  16  write data.
- ack  out  1  one-MCLK pulse on cycle completion.
- rdata  out  16  read data; valid from the ack pulse onward.
- berr_flag  out  1  1 = the last cycle was terminated by BERR; valid with ack.
- ADDRESS  out  23, FC  out  3, RW  out  1: bus address, function code and direction.
- AS, UDS, LDS  out  1  active-low strobes.
- DATA_OUT  out  16, DATA_OE  out  1: write data and its output enable.
- DATA_IN  in  16  bus read data.
- DTACK, BERR, VPA  in  1  active-low, synchronous to MCLK.
- E_CLK  out  1  6800 E clock. VMA  out  1  active-low valid memory address.

## Operation
- States: IDLE, S0–S7, SW (low-phase wait). Even states are entered on CLK_R and odd states on CLK_F; transitions happen only on strobes.
- IDLE/S7 → S0 on CLK_R when req = 1. At that edge, latch all req_* inputs and drive FC and RW (RW = req_rw). Otherwise S7 → IDLE.
- S1 entry: drive ADDRESS.
- S2 entry: AS = 0. On reads, UDS/LDS = ~req_uds/~req_lds.
- S3 entry: on writes, DATA_OE = 1 and DATA_OUT = req_wdata.
- S4 entry: on writes, assert UDS/LDS.
- Termination is sampled at the CLK_F that ends S4, with priority BERR > DTACK > VPA:
  - BERR = 0 → S5, set berr_flag.
  - DTACK = 0 → S5, clear berr_flag.
  - VPA = 0 → set vpa_mode; go to SW.
  - Otherwise → SW. SW returns to S4 on CLK_R, giving wait states in whole CPU clocks.
- VPA mode:
  - vpa_armed is set at the first CLK_R at which the new ecnt ≤ 5.
  - VMA = ~vpa_armed.
  - At the CLK_F that ends S4, vpa_armed = 1 and ecnt = 9 → S5. DTACK/BERR are still honoured first.
- At the CLK_F that ends S6 (S7 entry):
  - Reads: rdata ← DATA_IN, unless berr_flag is set, in which case rdata holds.
  - Pulse ack. AS = UDS = LDS = 1.
- At the CLK_R that ends S7: RW = 1, DATA_OE = 0, vpa_mode and vpa_armed cleared, VMA = 1.
- E clock:
  - ecnt runs 0–9, incremented at each CLK_R, wrapping 9 → 0.
  - E_CLK = 1 when ecnt ≥ 6 (6 clocks low, 4 high). It runs free, independent of bus state.
- Values on reset assertion:
  - State IDLE.
  - AS, UDS, LDS, VMA, RW = 1.
  - DATA_OE, ack, berr_flag, E_CLK = 0.
  - ADDRESS, FC, DATA_OUT, rdata, ecnt = 0.
  - Reset mid-cycle aborts the cycle with no ack.

## Timing
- Minimum cycle is 4 CPU clocks (8 half-states); each wait adds 1 CPU clock.
- The ack pulse is asserted in the MCLK following the S6-ending CLK_F.
- Back-to-back cycles: a new request is accepted on the CLK_R that ends S7, with no idle clock. The requester must change or drop req before that CLK_R.
- All outputs are registered. Strobe changes appear one MCLK after the CLK_R/CLK_F strobe that causes them.
- req is ignored in every state except IDLE and S7.

## Test plan
- Zero-wait read: DTACK tied 0, req_addr = 23'h091A2B, fc = 3'b110, both bytes, DATA_IN = 16'hBEEF → AS low S2–S6, UDS/LDS low with AS, ack after 4 CPU clocks, rdata = 16'hBEEF, berr_flag = 0.
- Write, 2 waits, lower byte only: DTACK low 2 CPU clocks late, wdata = 16'h1234 → LDS low from S4, UDS high, DATA_OE high S3–S7, RW low, ack after 6 CPU clocks.
- BERR and DTACK both low at S4 end → berr_flag = 1, rdata unchanged, ack still issued.
- VPA read issued with ecnt = 7 → VMA asserts at ecnt = 0, cycle ends at ecnt = 9, data latched at E fall, rdata = DATA_IN.
- Back-to-back reads with req held and fields changed after ack → second S0 immediately follows S7, with no IDLE state.
- RESET_N pulsed low during S4 of a write → all outputs return to reset values asynchronously, no ack, and the next request runs normally.
